// File: rtl/kim_pc_unit_if.sv
// kim_pc_unit_if: fetch-PC bus between the PC unit and the IF stage / pipeline control.
//   slave  modport: the PC unit (consumes stall/ready/redirects, drives pc and status).
//   master modport: the surrounding pipeline (drives stall/ready/redirects, observes pc).
// Signals:
//   pc_stall, if_ready                     : hazard stall and instruction-memory ready
//   redir_ex_valid/target, redir_id_valid/target, trap_valid : redirect sources
//   pc, pc_valid, pc_plus                   : fetch address, request valid, pc + increment
//   redir_pending, misalign_err             : deferred-ID status, misaligned-target pulse
//   ras_push, ras_pop, ras_empty            : return-address stack (only with KIM_PC_RAS_EN)
interface kim_pc_unit_if #(
  parameter int unsigned PC_ADDR_WIDTH = 32
) ();
  logic                     pc_stall;
  logic                     if_ready;
  logic                     redir_ex_valid;
  logic [PC_ADDR_WIDTH-1:0] redir_ex_target;
  logic                     redir_id_valid;
  logic [PC_ADDR_WIDTH-1:0] redir_id_target;
  logic                     trap_valid;
  logic [PC_ADDR_WIDTH-1:0] pc;
  logic                     pc_valid;
  logic [PC_ADDR_WIDTH-1:0] pc_plus;
  logic                     redir_pending;
  logic                     misalign_err;
`ifdef KIM_PC_RAS_EN
  logic                     ras_push;
  logic                     ras_pop;
  logic                     ras_empty;
`endif

  modport slave (
    input  pc_stall, if_ready, redir_ex_valid, redir_ex_target,
    input  redir_id_valid, redir_id_target, trap_valid,
`ifdef KIM_PC_RAS_EN
    input  ras_push, ras_pop,
    output ras_empty,
`endif
    output pc, pc_valid, pc_plus, redir_pending, misalign_err
  );

  modport master (
    output pc_stall, if_ready, redir_ex_valid, redir_ex_target,
    output redir_id_valid, redir_id_target, trap_valid,
`ifdef KIM_PC_RAS_EN
    output ras_push, ras_pop,
    input  ras_empty,
`endif
    input  pc, pc_valid, pc_plus, redir_pending, misalign_err
  );
endinterface

// File: rtl/kim_pc_unit.sv
// kim_pc_unit: fetch program counter at the head of the IF stage.
//   Holds the fetch PC, generates pc + PC_INC, and arbitrates trap, EX and ID redirects
//   under hazard stalls and instruction-memory back-pressure. An ID redirect that cannot be
//   taken immediately is parked (HOLD) until the PC next advances.
// Ports:
//   clk  : clock, rising edge
//   rst  : asynchronous active-high reset
//   bus  : kim_pc_unit_if.slave (stall/ready/redirect inputs; pc, pc_valid, pc_plus,
//          redir_pending, misalign_err outputs; ras_push/ras_pop/ras_empty when enabled)
// Optional feature: define KIM_PC_RAS_EN to add a RAS_DEPTH-entry circular return-address
// stack (push stores pc_plus, pop loads the top entry) ranked below EX and above ID.
module kim_pc_unit #(
  parameter int unsigned              PC_ADDR_WIDTH = 32,
  parameter int unsigned              PC_INC        = 4,
  parameter logic [PC_ADDR_WIDTH-1:0] RESET_VECTOR  = 'h0000_1000,
  parameter logic [PC_ADDR_WIDTH-1:0] TRAP_VECTOR   = 'h0000_0080,
  parameter int unsigned              RAS_DEPTH     = 4
) (
  input logic          clk,
  input logic          rst,
  kim_pc_unit_if.slave bus
);

  // Parameter sanity checks at elaboration.
  if (PC_INC == 0 || (PC_INC & (PC_INC - 1)) != 0) begin : g_bad_inc
    $error("kim_pc_unit: PC_INC must be a power of two");
  end
  if (RAS_DEPTH == 0) begin : g_bad_ras
    $error("kim_pc_unit: RAS_DEPTH must be at least 1");
  end

  // Low address bits that must be zero in any loaded target.
  localparam logic [PC_ADDR_WIDTH-1:0] LowMask = PC_ADDR_WIDTH'(PC_INC - 1);

  typedef enum logic [1:0] {StBoot, StRun, StHold} state_e;

  state_e                   state_q;
  logic [PC_ADDR_WIDTH-1:0] pc_q;
  logic                     pc_valid_q;
  logic                     pend_q;
  logic [PC_ADDR_WIDTH-1:0] pend_tgt_q;  // raw target, aligned when loaded
  logic                     misalign_q;

  logic [PC_ADDR_WIDTH-1:0] pc_plus;
  logic                     adv;
  logic                     flush;
  logic                     ras_pop_take;
  logic [PC_ADDR_WIDTH-1:0] ras_top;

  function automatic logic [PC_ADDR_WIDTH-1:0] align_tgt(input logic [PC_ADDR_WIDTH-1:0] t);
    return t & ~LowMask;
  endfunction

  function automatic logic is_misal(input logic [PC_ADDR_WIDTH-1:0] t);
    return |(t & LowMask);
  endfunction

  assign pc_plus = pc_q + PC_ADDR_WIDTH'(PC_INC);
  assign adv     = pc_valid_q & ~bus.pc_stall & bus.if_ready;
  assign flush   = bus.trap_valid | bus.redir_ex_valid;

`ifdef KIM_PC_RAS_EN
  localparam int unsigned RasPtrW = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;
  localparam int unsigned RasCntW = $clog2(RAS_DEPTH + 1);

  logic [PC_ADDR_WIDTH-1:0] ras_mem_q [RAS_DEPTH];
  logic [RasPtrW-1:0]       ras_wr_q;     // next slot to write
  logic [RasPtrW-1:0]       ras_top_idx;  // most recently written slot
  logic [RasPtrW-1:0]       ras_wr_inc;
  logic [RasCntW-1:0]       ras_cnt_q;
  logic                     ras_empty;
  logic                     ras_full;
  logic                     ras_push_take;

  assign ras_top_idx   = (ras_wr_q == '0) ? RasPtrW'(RAS_DEPTH - 1) : ras_wr_q - RasPtrW'(1);
  assign ras_wr_inc    = (ras_wr_q == RasPtrW'(RAS_DEPTH - 1)) ? '0 : ras_wr_q + RasPtrW'(1);
  assign ras_empty     = (ras_cnt_q == '0);
  assign ras_full      = (ras_cnt_q == RasCntW'(RAS_DEPTH));
  assign ras_top       = ras_mem_q[ras_top_idx];
  // Push/pop only act on an advancing, non-flushed fetch; pop on empty falls through.
  assign ras_push_take = bus.ras_push & adv & ~flush;
  assign ras_pop_take  = bus.ras_pop & adv & ~flush & ~ras_empty;
  assign bus.ras_empty = ras_empty;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ras_wr_q  <= '0;
      ras_cnt_q <= '0;
    end else if (ras_push_take && !ras_pop_take) begin
      ras_wr_q  <= ras_wr_inc;
      // A full stack overwrites its oldest entry, so the count saturates.
      if (!ras_full) ras_cnt_q <= ras_cnt_q + RasCntW'(1);
    end else if (ras_pop_take && !ras_push_take) begin
      ras_wr_q  <= ras_top_idx;
      ras_cnt_q <= ras_cnt_q - RasCntW'(1);
    end
  end

  // Storage is not reset; the count alone defines validity.
  always_ff @(posedge clk) begin
    if (ras_push_take && ras_pop_take) begin
      ras_mem_q[ras_top_idx] <= pc_plus;  // push+pop replaces the top entry
    end else if (ras_push_take) begin
      ras_mem_q[ras_wr_q] <= pc_plus;
    end
  end
`else
  assign ras_pop_take = 1'b0;
  assign ras_top      = '0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= StBoot;
      pc_q       <= RESET_VECTOR;
      pc_valid_q <= 1'b0;
      pend_q     <= 1'b0;
      pend_tgt_q <= '0;
      misalign_q <= 1'b0;
    end else begin
      misalign_q <= 1'b0;
      // BOOT lasts one cycle; later branches may still redirect the state.
      if (state_q == StBoot) begin
        state_q    <= StRun;
        pc_valid_q <= 1'b1;
      end
      if (bus.trap_valid) begin
        pc_q       <= align_tgt(TRAP_VECTOR);
        misalign_q <= is_misal(TRAP_VECTOR);
        pend_q     <= 1'b0;
        state_q    <= StRun;
      end else if (bus.redir_ex_valid) begin
        pc_q       <= align_tgt(bus.redir_ex_target);
        misalign_q <= is_misal(bus.redir_ex_target);
        pend_q     <= 1'b0;
        state_q    <= StRun;
      end else if (ras_pop_take) begin
        pc_q    <= ras_top;
        pend_q  <= 1'b0;
        state_q <= StRun;
      end else if (bus.redir_id_valid && adv) begin
        pc_q       <= align_tgt(bus.redir_id_target);
        misalign_q <= is_misal(bus.redir_id_target);
        pend_q     <= 1'b0;
        state_q    <= StRun;
      end else if (bus.redir_id_valid) begin
        // Newest deferred ID target replaces any older one.
        pend_tgt_q <= bus.redir_id_target;
        pend_q     <= 1'b1;
        state_q    <= StHold;
      end else if (state_q == StHold && adv) begin
        pc_q       <= align_tgt(pend_tgt_q);
        misalign_q <= is_misal(pend_tgt_q);
        pend_q     <= 1'b0;
        state_q    <= StRun;
      end else if (adv) begin
        pc_q <= pc_plus;
      end
    end
  end

  assign bus.pc            = pc_q;
  assign bus.pc_valid      = pc_valid_q;
  assign bus.pc_plus       = pc_plus;
  assign bus.redir_pending = pend_q;
  assign bus.misalign_err  = misalign_q;

endmodule

// File: tb/tb_kim_pc_unit.sv
// tb_kim_pc_unit: directed self-checking bench for kim_pc_unit (default parameters).
// RAS steps are compiled in only when KIM_PC_RAS_EN is defined.
module tb_kim_pc_unit;
  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  kim_pc_unit_if #(.PC_ADDR_WIDTH(32)) bus ();

  kim_pc_unit #(
    .PC_ADDR_WIDTH(32),
    .PC_INC       (4),
    .RESET_VECTOR (32'h0000_1000),
    .TRAP_VECTOR  (32'h0000_0080),
    .RAS_DEPTH    (4)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance one clock and settle just after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.pc_stall        = 1'b0;
    bus.redir_ex_valid  = 1'b0;
    bus.redir_ex_target = '0;
    bus.redir_id_valid  = 1'b0;
    bus.redir_id_target = '0;
    bus.trap_valid      = 1'b0;
`ifdef KIM_PC_RAS_EN
    bus.ras_push = 1'b0;
    bus.ras_pop  = 1'b0;
`endif
  endtask

  initial begin
    rst = 1'b1;
    bus.if_ready = 1'b1;
    idle_inputs();
    repeat (2) tick();

    // Reset state
    check("rst_pc", bus.pc, 32'h0000_1000);
    check("rst_valid", {31'b0, bus.pc_valid}, 32'd0);
    check("rst_pending", {31'b0, bus.redir_pending}, 32'd0);
    check("rst_misal", {31'b0, bus.misalign_err}, 32'd0);
    check("rst_pc_plus", bus.pc_plus, 32'h0000_1004);
    rst = 1'b0;
    #1;
    check("boot_valid", {31'b0, bus.pc_valid}, 32'd0);

    // Boot then sequential fetch
    tick();
    check("run_pc0", bus.pc, 32'h0000_1000);
    check("run_valid", {31'b0, bus.pc_valid}, 32'd1);
    tick();
    check("run_pc1", bus.pc, 32'h0000_1004);
    tick();
    check("run_pc2", bus.pc, 32'h0000_1008);

    // Deferred ID redirect during a 3-cycle stall
    bus.pc_stall = 1'b1;
    bus.redir_id_valid = 1'b1;
    bus.redir_id_target = 32'h0000_2000;
    tick();
    check("stall_pc_a", bus.pc, 32'h0000_1008);
    check("stall_pend_a", {31'b0, bus.redir_pending}, 32'd1);
    bus.redir_id_valid = 1'b0;
    tick();
    check("stall_pc_b", bus.pc, 32'h0000_1008);
    tick();
    check("stall_pend_c", {31'b0, bus.redir_pending}, 32'd1);
    bus.pc_stall = 1'b0;
    tick();
    check("hold_drop_pc", bus.pc, 32'h0000_2000);
    check("hold_drop_pend", {31'b0, bus.redir_pending}, 32'd0);

    // EX redirect during HOLD discards the pending target
    bus.pc_stall = 1'b1;
    bus.redir_id_valid = 1'b1;
    bus.redir_id_target = 32'h0000_2000;
    tick();
    check("hold2_pend", {31'b0, bus.redir_pending}, 32'd1);
    bus.redir_id_valid = 1'b0;
    bus.redir_ex_valid = 1'b1;
    bus.redir_ex_target = 32'h0000_3000;
    tick();
    check("ex_over_hold_pc", bus.pc, 32'h0000_3000);
    check("ex_over_hold_pend", {31'b0, bus.redir_pending}, 32'd0);
    idle_inputs();
    tick();
    check("ex_over_hold_next", bus.pc, 32'h0000_3004);

    // Trap beats EX and ID
    bus.trap_valid = 1'b1;
    bus.redir_ex_valid = 1'b1;
    bus.redir_ex_target = 32'h0000_4000;
    bus.redir_id_valid = 1'b1;
    bus.redir_id_target = 32'h0000_5000;
    tick();
    check("trap_pc", bus.pc, 32'h0000_0080);
    idle_inputs();
    tick();
    check("trap_next", bus.pc, 32'h0000_0084);

    // Back-pressure holds pc
    bus.if_ready = 1'b0;
    tick();
    check("ifready_hold", bus.pc, 32'h0000_0084);
    bus.if_ready = 1'b1;

    // ID redirect with advance loads immediately
    bus.redir_id_valid = 1'b1;
    bus.redir_id_target = 32'h0000_6000;
    tick();
    check("id_adv_pc", bus.pc, 32'h0000_6000);
    idle_inputs();

    // Wrap-around and misaligned EX target
    bus.redir_ex_valid = 1'b1;
    bus.redir_ex_target = 32'hFFFF_FFFC;
    tick();
    check("wrap_load", bus.pc, 32'hFFFF_FFFC);
    check("wrap_plus", bus.pc_plus, 32'h0000_0000);
    idle_inputs();
    tick();
    check("wrap_pc", bus.pc, 32'h0000_0000);
    check("wrap_misal", {31'b0, bus.misalign_err}, 32'd0);
    bus.redir_ex_valid = 1'b1;
    bus.redir_ex_target = 32'h0000_1002;
    tick();
    check("misal_pc", bus.pc, 32'h0000_1000);
    check("misal_pulse", {31'b0, bus.misalign_err}, 32'd1);
    idle_inputs();
    tick();
    check("misal_clear", {31'b0, bus.misalign_err}, 32'd0);
    check("misal_next", bus.pc, 32'h0000_1004);

    // Misaligned deferred ID target is aligned when it finally loads
    bus.pc_stall = 1'b1;
    bus.redir_id_valid = 1'b1;
    bus.redir_id_target = 32'h0000_7001;
    tick();
    check("pend_misal_early", {31'b0, bus.misalign_err}, 32'd0);
    idle_inputs();
    tick();
    check("pend_misal_pc", bus.pc, 32'h0000_7000);
    check("pend_misal_pulse", {31'b0, bus.misalign_err}, 32'd1);

    // Mid-operation reset aborts a pending redirect at once
    bus.pc_stall = 1'b1;
    bus.redir_id_valid = 1'b1;
    bus.redir_id_target = 32'h0000_8000;
    tick();
    check("pre_rst_pend", {31'b0, bus.redir_pending}, 32'd1);
    idle_inputs();
    #2;
    rst = 1'b1;
    #1;
    check("async_rst_pc", bus.pc, 32'h0000_1000);
    check("async_rst_pend", {31'b0, bus.redir_pending}, 32'd0);
    check("async_rst_valid", {31'b0, bus.pc_valid}, 32'd0);
    rst = 1'b0;
    tick();
    check("reboot_pc", bus.pc, 32'h0000_1000);
    check("reboot_valid", {31'b0, bus.pc_valid}, 32'd1);

`ifdef KIM_PC_RAS_EN
    // Return-address stack: push at 0x1000, jump, pop returns to 0x1004
    bus.ras_push = 1'b1;
    tick();
    check("ras_push_pc", bus.pc, 32'h0000_1004);
    check("ras_not_empty", {31'b0, bus.ras_empty}, 32'd0);
    idle_inputs();
    bus.redir_ex_valid = 1'b1;
    bus.redir_ex_target = 32'h0000_2000;
    tick();
    check("ras_jump_pc", bus.pc, 32'h0000_2000);
    idle_inputs();
    bus.ras_pop = 1'b1;
    tick();
    check("ras_pop_pc", bus.pc, 32'h0000_1004);
    check("ras_empty_after", {31'b0, bus.ras_empty}, 32'd1);
    tick();
    check("ras_pop_empty_pc", bus.pc, 32'h0000_1008);
    check("ras_pop_empty_flag", {31'b0, bus.ras_empty}, 32'd1);
    idle_inputs();
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
